memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/memory_stage_if.sv | 47 ++++
 rtl/memory_stage_mem_wb.sv | 75 +++++++
 rtl/memory_stage.sv | 166 ++++++++++++++++
 tb/tb_memory_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg (package)
// Description : Shared pipeline definitions. Holds the default datapath and
//               data-memory address widths, the register-index width, the
//               memory-stage FSM state type and a small alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_ADDR_W = 32;
    localparam int REG_IDX_W   = 5;

    // Memory-stage access FSM: IDLE issues requests, WAIT_R waits for load data.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } mem_state_t;

    // Word accesses only: any set bit in the byte offset is a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_if (interface)
// Description : Data-memory request/response bundle between the memory stage
//               and the data memory.
//               master : memory stage (drives dmem_req/we/addr/wdata)
//               slave  : data memory  (drives dmem_gnt/rvalid/rdata)
// Parameters  : DATA_W - data width, ADDR_W - address width
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_stage_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ADDR_W = PIPE_ADDR_W
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );

endinterface : memory_stage_if
`default_nettype wire

// File: rtl/memory_stage_mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : regMemorytoWriteback
// Description : MEM/WB pipeline register. On a bubble the control bits are
//               cleared and the data fields hold; otherwise all fields load.
//               Read data loads only when a load response is accepted.
// Ports       : clk, rst (async, active-high)
//               i_bubble   - insert bubble this edge
//               i_rd_load  - capture i_rdata into readdata
//               i_regwrite/i_memtoreg/i_aluout/i_writereg/i_rdata - inputs
//               o_*        - registered MEM/WB contents
// Revision    : 1.0 - initial release
// ============================================================================
module regMemorytoWriteback
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_bubble,
    input  wire logic                 i_rd_load,
    input  wire logic                 i_regwrite,
    input  wire logic                 i_memtoreg,
    input  wire logic [DATA_W-1:0]    i_aluout,
    input  wire logic [REG_IDX_W-1:0] i_writereg,
    input  wire logic [DATA_W-1:0]    i_rdata,
    output logic                      o_regwrite,
    output logic                      o_memtoreg,
    output logic [DATA_W-1:0]         o_readdata,
    output logic [DATA_W-1:0]         o_aluout,
    output logic [REG_IDX_W-1:0]      o_writereg
);

    logic                 r_regwrite;
    logic                 r_memtoreg;
    logic [DATA_W-1:0]    r_readdata;
    logic [DATA_W-1:0]    r_aluout;
    logic [REG_IDX_W-1:0] r_writereg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluout   <= '0;
            r_writereg <= '0;
        end else if (i_bubble) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else begin
            r_regwrite <= i_regwrite;
            r_memtoreg <= i_memtoreg;
            r_aluout   <= i_aluout;
            r_writereg <= i_writereg;
        end
    end

    // Read data is independent of the bubble path: it only changes when a
    // load response is accepted, otherwise the last load value is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readdata <= '0;
        end else if (i_rd_load) begin
            r_readdata <= i_rdata;
        end
    end

    assign o_regwrite = r_regwrite;
    assign o_memtoreg = r_memtoreg;
    assign o_readdata = r_readdata;
    assign o_aluout   = r_aluout;
    assign o_writereg = r_writereg;

endmodule : regMemorytoWriteback
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline memory stage. Issues data-memory requests for loads
//               and stores, stalls the pipeline until the access completes,
//               and feeds the MEM/WB register (regMemorytoWriteback).
// Ports       : clk, reset (async, active-high)
//               regwriteM/memtoregM/memwriteM, aluoutM, writedataM, writeregM
//                          - EX/MEM register contents
//               dmem       - data-memory bundle (memory_stage_if.master)
//               stallM     - access not yet complete; hold EX/MEM and earlier
//               regwriteW/memtoregW/readdataW/aluoutW/writeregW - MEM/WB
//               resultW    - write-back / forwarding value
//               misalignW  - (MEMSTAGE_ALIGN_CHECK_EN only) misaligned access
// Config      : MEMSTAGE_ALIGN_CHECK_EN - drop misaligned accesses as bubbles
//               and flag them on misalignW for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 regwriteM,
    input  wire logic                 memtoregM,
    input  wire logic                 memwriteM,
    input  wire logic [DATA_W-1:0]    aluoutM,
    input  wire logic [DATA_W-1:0]    writedataM,
    input  wire logic [REG_IDX_W-1:0] writeregM,
    memory_stage_if.master            dmem,
    output logic                      stallM,
    output logic                      regwriteW,
    output logic                      memtoregW,
    output logic [DATA_W-1:0]         readdataW,
    output logic [DATA_W-1:0]         aluoutW,
    output logic [REG_IDX_W-1:0]      writeregW,
    output logic [DATA_W-1:0]         resultW
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    ,
    output logic                      misalignW
`endif
);

    mem_state_t r_state;
    mem_state_t w_next_state;

    logic w_access;
    logic w_misalign;
    logic w_issue;
    logic w_rd_load;
    logic w_bubble;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_access = memwriteM | memtoregM;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
    assign w_misalign = w_access & is_misaligned(aluoutM[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_access & ~w_misalign;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and request / stall outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = memwriteM;
        dmem.dmem_addr  = aluoutM[ADDR_W-1:0];
        dmem.dmem_wdata = writedataM;
        stallM          = 1'b0;
        w_rd_load       = 1'b0;

        case (r_state)
            IDLE: begin
                // rvalid is not looked at here, so stray responses are ignored.
                dmem.dmem_req = w_issue;
                if (w_issue) begin
                    if (!dmem.dmem_gnt) begin
                        // Hold the request; EX/MEM is frozen so fields stay stable.
                        stallM = 1'b1;
                    end else if (memtoregM) begin
                        // Granted load: data arrives later, keep stalling.
                        stallM       = 1'b1;
                        w_next_state = WAIT_R;
                    end
                end
            end

            WAIT_R: begin
                // gnt is not looked at here.
                stallM = ~dmem.dmem_rvalid;
                if (dmem.dmem_rvalid) begin
                    w_rd_load    = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A misaligned access never stalls but must not write back.
    assign w_bubble = stallM | w_misalign;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    regMemorytoWriteback #(
        .DATA_W (DATA_W)
    ) u_mem_wb (
        .clk        (clk),
        .rst        (reset),
        .i_bubble   (w_bubble),
        .i_rd_load  (w_rd_load),
        .i_regwrite (regwriteM),
        .i_memtoreg (memtoregM),
        .i_aluout   (aluoutM),
        .i_writereg (writeregM),
        .i_rdata    (dmem.dmem_rdata),
        .o_regwrite (regwriteW),
        .o_memtoreg (memtoregW),
        .o_readdata (readdataW),
        .o_aluout   (aluoutW),
        .o_writereg (writeregW)
    );

    assign resultW = memtoregW ? readdataW : aluoutW;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
    logic r_misalignW;

    // Single-cycle flag aligned with the bubble entering MEM/WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalignW <= 1'b0;
        end else begin
            r_misalignW <= w_misalign & (r_state == IDLE);
        end
    end

    assign misalignW = r_misalignW;
`endif

endmodule : memory_stage
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed self-checking bench for memory_stage. Drives the
//               data-memory responder by hand and compares against
//               hand-computed expected values.
// Config      : MEMSTAGE_ALIGN_CHECK_EN selects the misalignment scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    localparam int C_DW = 32;
    localparam int C_AW = 32;

    logic            clk;
    logic            reset;
    logic            regwriteM;
    logic            memtoregM;
    logic            memwriteM;
    logic [C_DW-1:0] aluoutM;
    logic [C_DW-1:0] writedataM;
    logic [4:0]      writeregM;
    logic            stallM;
    logic            regwriteW;
    logic            memtoregW;
    logic [C_DW-1:0] readdataW;
    logic [C_DW-1:0] aluoutW;
    logic [4:0]      writeregW;
    logic [C_DW-1:0] resultW;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    logic            misalignW;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    memory_stage_if #(.DATA_W(C_DW), .ADDR_W(C_AW)) dmem_if ();

    memory_stage #(
        .DATA_W (C_DW),
        .ADDR_W (C_AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .regwriteM  (regwriteM),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .writeregM  (writeregM),
        .dmem       (dmem_if),
        .stallM     (stallM),
        .regwriteW  (regwriteW),
        .memtoregW  (memtoregW),
        .readdataW  (readdataW),
        .aluoutW    (aluoutW),
        .writeregW  (writeregW),
        .resultW    (resultW)
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        ,
        .misalignW  (misalignW)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        regwriteM  = 1'b0;
        memtoregM  = 1'b0;
        memwriteM  = 1'b0;
        aluoutM    = '0;
        writedataM = '0;
        writeregM  = '0;
    endtask

    initial begin
        reset                = 1'b1;
        set_nop();
        dmem_if.dmem_gnt     = 1'b0;
        dmem_if.dmem_rvalid  = 1'b0;
        dmem_if.dmem_rdata   = '0;

        // ---------------- reset state ----------------
        step();
        step();
        check_val("rst_regwriteW", regwriteW, 0);
        check_val("rst_memtoregW", memtoregW, 0);
        check_val("rst_readdataW", readdataW, 0);
        check_val("rst_aluoutW",   aluoutW,   0);
        check_val("rst_writeregW", writeregW, 0);
        check_val("rst_stallM",    stallM,    0);
        check_val("rst_req",       dmem_if.dmem_req, 0);
        reset = 1'b0;

        // ---------------- ALU op passes in one cycle ----------------
        regwriteM = 1'b1;
        aluoutM   = 32'h0000_0010;
        writeregM = 5'd5;
        #1;
        check_val("alu_stall", stallM, 0);
        check_val("alu_req",   dmem_if.dmem_req, 0);
        step();
        check_val("alu_regwriteW", regwriteW, 1);
        check_val("alu_resultW",   resultW,   32'h10);
        check_val("alu_writeregW", writeregW, 5);
        check_val("alu_stall2",    stallM,    0);

        // ---------------- store with grant held low 3 cycles ----------------
        set_nop();
        memwriteM  = 1'b1;
        aluoutM    = 32'h0000_0040;
        writedataM = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("st_stall%0d", i), stallM, 1);
            check_val($sformatf("st_req%0d", i),   dmem_if.dmem_req, 1);
            check_val($sformatf("st_we%0d", i),    dmem_if.dmem_we, 1);
            check_val($sformatf("st_addr%0d", i),  dmem_if.dmem_addr, 32'h40);
            check_val($sformatf("st_wdata%0d", i), dmem_if.dmem_wdata, 32'hDEAD_BEEF);
            step();
            // Bubble: control cleared, data fields hold the ALU op.
            check_val($sformatf("st_bub_rw%0d", i),  regwriteW, 0);
            check_val($sformatf("st_bub_alu%0d", i), aluoutW, 32'h10);
        end
        dmem_if.dmem_gnt = 1'b1;
        #1;
        check_val("st_gnt_stall", stallM, 0);
        check_val("st_gnt_req",   dmem_if.dmem_req, 1);
        step();
        check_val("st_done_alu", aluoutW, 32'h40);
        check_val("st_done_rw",  regwriteW, 0);

        // ---------------- load, immediate grant, rvalid 2 cycles later ----------------
        set_nop();
        regwriteM = 1'b1;
        memtoregM = 1'b1;
        aluoutM   = 32'h0000_0080;
        writeregM = 5'd7;
        #1;
        check_val("ld_gnt_stall", stallM, 1);
        check_val("ld_gnt_req",   dmem_if.dmem_req, 1);
        check_val("ld_gnt_we",    dmem_if.dmem_we, 0);
        step();
        // gnt left high in WAIT_R: must be ignored.
        check_val("ld_wait_req",   dmem_if.dmem_req, 0);
        check_val("ld_wait_stall", stallM, 1);
        check_val("ld_wait_rw",    regwriteW, 0);
        step();
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = 32'h1234_5678;
        #1;
        check_val("ld_rv_stall", stallM, 0);
        step();
        dmem_if.dmem_rvalid = 1'b0;
        dmem_if.dmem_gnt    = 1'b0;
        check_val("ld_resultW",   resultW,   32'h1234_5678);
        check_val("ld_memtoregW", memtoregW, 1);
        check_val("ld_regwriteW", regwriteW, 1);
        check_val("ld_writeregW", writeregW, 7);

        // ---------------- stray rvalid in IDLE is ignored ----------------
        set_nop();
        aluoutM             = 32'h0000_0020;
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = 32'hBAD0_BAD0;
        #1;
        check_val("stray_stall", stallM, 0);
        step();
        dmem_if.dmem_rvalid = 1'b0;
        check_val("stray_readdataW", readdataW, 32'h1234_5678);
        check_val("stray_resultW",   resultW,   32'h20);

        // ---------------- reset asserted in WAIT_R ----------------
        set_nop();
        regwriteM = 1'b1;
        memtoregM = 1'b1;
        aluoutM   = 32'h0000_0090;
        writeregM = 5'd9;
        dmem_if.dmem_gnt = 1'b1;
        step();
        check_val("rw_in_wait", stallM, 1);
        #2;
        set_nop();
        dmem_if.dmem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        // No clock edge yet: asynchronous reset must already be visible.
        check_val("rw_stall",     stallM,    0);
        check_val("rw_regwriteW", regwriteW, 0);
        check_val("rw_memtoregW", memtoregW, 0);
        check_val("rw_readdataW", readdataW, 0);
        check_val("rw_aluoutW",   aluoutW,   0);
        step();
        reset = 1'b0;
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = 32'hCAFE_F00D;
        #1;
        check_val("rw_late_stall", stallM, 0);
        step();
        dmem_if.dmem_rvalid = 1'b0;
        check_val("rw_late_readdataW", readdataW, 0);
        check_val("rw_late_regwriteW", regwriteW, 0);
        check_val("rw_late_resultW",   resultW,   0);
        check_val("rw_late_writeregW", writeregW, 0);

`ifdef MEMSTAGE_ALIGN_CHECK_EN
        // ---------------- misaligned load is dropped ----------------
        set_nop();
        regwriteM = 1'b1;
        aluoutM   = 32'h0000_0033;
        writeregM = 5'd4;
        step();
        check_val("al_pre_rw", regwriteW, 1);
        memtoregM = 1'b1;
        aluoutM   = 32'h0000_0042;
        writeregM = 5'd3;
        dmem_if.dmem_gnt = 1'b1;
        #1;
        check_val("al_req",   dmem_if.dmem_req, 0);
        check_val("al_stall", stallM, 0);
        step();
        check_val("al_misalignW", misalignW, 1);
        check_val("al_regwriteW", regwriteW, 0);
        check_val("al_memtoregW", memtoregW, 0);
        set_nop();
        dmem_if.dmem_gnt = 1'b0;
        step();
        check_val("al_misalign_clr", misalignW, 0);
`else
        // ---------------- unaligned address passes unchecked ----------------
        set_nop();
        memwriteM  = 1'b1;
        aluoutM    = 32'h0000_0043;
        writedataM = 32'h0BAD_F00D;
        dmem_if.dmem_gnt = 1'b1;
        #1;
        check_val("ua_req",   dmem_if.dmem_req, 1);
        check_val("ua_addr",  dmem_if.dmem_addr, 32'h43);
        check_val("ua_stall", stallM, 0);
        step();
        set_nop();
        dmem_if.dmem_gnt = 1'b0;
        check_val("ua_aluoutW", aluoutW, 32'h43);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_memory_stage
`default_nettype wire
